sprite_pixel_fetch: RTL and testbench

Read-side client for the per-fighter sprite ROMs. Every pixel clock it turns the VGA raster position and a fighter's screen position into a 14-bit ROM address, a mirror flag and a ROM-select code. It then aligns the returned 12-bit RGB with a valid/opaque qualifier for the compositor. It also runs the fighter's animation state machine (idle / walk cycle / one-shot punch) and changes sprites only on frame boundaries.

---
 rtl/sprite_pixel_fetch.sv | 146 ++++++++++++++
 tb/tb_sprite_pixel_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_fetch.sv
// Sprite ROM read client: raster-to-address mapping, 2-cycle pixel alignment
// and the per-fighter animation FSM (idle / walk cycle / one-shot punch).
module sprite_pixel_fetch #(
  parameter int          SPRITE_DIM   = 128,
  parameter int          STEP_FRAMES  = 8,
  parameter int          PUNCH_FRAMES = 12,
  parameter logic [11:0] KEY_COLOR    = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        facing_left,
  input  logic        frame_tick,
  input  logic [1:0]  anim_req,
  input  logic [11:0] rom_pixel,
  output logic [13:0] rom_addr,
  output logic        rom_reverse,
  output logic [1:0]  rom_sel,
  output logic [11:0] pix_rgb,
  output logic        pix_valid,
  output logic        pix_opaque,
  output logic        punch_active
);

  localparam int MAXF = (STEP_FRAMES > PUNCH_FRAMES) ? STEP_FRAMES : PUNCH_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);

  // Encoding doubles as the rom_sel code.
  typedef enum logic [1:0] {IDLE = 2'd0, WALK_A = 2'd1, WALK_B = 2'd2, PUNCH = 2'd3} state_t;

  state_t        state_q, state_d, state_nx;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [13:0]   rom_addr_q, rom_addr_d;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic          rom_reverse_q, rom_reverse_d;
  logic [1:0]    rom_sel_q, rom_sel_d;
  logic [11:0]   pix_rgb_q, pix_rgb_d;
  logic          pix_valid_q, pix_valid_d;
  logic          pix_opaque_q, pix_opaque_d;
  logic          punch_active_q, punch_active_d;

  logic [10:0]   hx, vy, sx, sy;
  logic          in_box;
  logic [6:0]    dx, dy;

  always_comb begin
    // 11-bit compare so a sprite near the right/bottom edge never wraps to 0.
    hx = {1'b0, hcount};
    vy = {1'b0, vcount};
    sx = {1'b0, sprite_x};
    sy = {1'b0, sprite_y};
    in_box = video_on && (hx >= sx) && (hx < sx + 11'(SPRITE_DIM)) &&
             (vy >= sy) && (vy < sy + 11'(SPRITE_DIM));
    dx = hcount[6:0] - sprite_x[6:0];
    dy = vcount[6:0] - sprite_y[6:0];
    rom_addr_d = in_box ? {dy, dx} : 14'd0;
    v1_d = in_box;
    v2_d = v1_q;

    pix_valid_d  = v2_q;
    pix_rgb_d    = v2_q ? rom_pixel : 12'h000;
    pix_opaque_d = v2_q && (rom_pixel != KEY_COLOR);
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_nx = '0;
        if (anim_req == 2'd2)      state_nx = PUNCH;
        else if (anim_req == 2'd1) state_nx = WALK_A;
      end
      WALK_A, WALK_B: begin
        if (anim_req == 2'd2) begin
          state_nx = PUNCH;
          cnt_nx   = '0;
        end else if (anim_req != 2'd1) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt_q == CW'(STEP_FRAMES - 1)) begin
          state_nx = (state_q == WALK_A) ? WALK_B : WALK_A;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      default: begin
        // Punch runs to completion; new punch requests are not latched.
        if (cnt_q == CW'(PUNCH_FRAMES - 1)) begin
          state_nx = (anim_req == 2'd1) ? WALK_A : IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
    endcase

    state_d        = frame_tick ? state_nx : state_q;
    cnt_d          = frame_tick ? cnt_nx : cnt_q;
    rom_sel_d      = frame_tick ? 2'(state_nx) : rom_sel_q;
    rom_reverse_d  = frame_tick ? facing_left : rom_reverse_q;
    punch_active_d = (state_d == PUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rom_addr_q     <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      rom_reverse_q  <= 1'b0;
      rom_sel_q      <= 2'd0;
      pix_rgb_q      <= '0;
      pix_valid_q    <= 1'b0;
      pix_opaque_q   <= 1'b0;
      punch_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rom_addr_q     <= rom_addr_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      rom_reverse_q  <= rom_reverse_d;
      rom_sel_q      <= rom_sel_d;
      pix_rgb_q      <= pix_rgb_d;
      pix_valid_q    <= pix_valid_d;
      pix_opaque_q   <= pix_opaque_d;
      punch_active_q <= punch_active_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_reverse  = rom_reverse_q;
  assign rom_sel      = rom_sel_q;
  assign pix_rgb      = pix_rgb_q;
  assign pix_valid    = pix_valid_q;
  assign pix_opaque   = pix_opaque_q;
  assign punch_active = punch_active_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: address mapping, pixel latency,
// key color, edge clipping, walk/punch animation and async reset.
module tb_sprite_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount, sprite_x, sprite_y;
  logic        video_on, facing_left, frame_tick;
  logic [1:0]  anim_req;
  logic [11:0] rom_pixel;
  logic [13:0] rom_addr;
  logic        rom_reverse, pix_valid, pix_opaque, punch_active;
  logic [1:0]  rom_sel;
  logic [11:0] pix_rgb;
  logic        key_force;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_rgb [0:139];
  logic        exp_v   [0:139];

  always #5 clk = ~clk;

  // Registered-read ROM model: data = low 12 address bits, or the key color.
  always_ff @(posedge clk) rom_pixel <= key_force ? 12'hF0F : rom_addr[11:0];

  sprite_pixel_fetch dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .facing_left(facing_left), .frame_tick(frame_tick), .anim_req(anim_req),
    .rom_pixel(rom_pixel), .rom_addr(rom_addr), .rom_reverse(rom_reverse),
    .rom_sel(rom_sel), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .pix_opaque(pix_opaque), .punch_active(punch_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic probe(input logic [9:0] h, input logic [9:0] v, input string tag,
                       input logic exp_valid);
    hcount = h;
    vcount = v;
    repeat (3) step();
    check(tag, {31'd0, pix_valid}, {31'd0, exp_valid});
  endtask

  initial begin
    rst_n = 1'b0; hcount = 0; vcount = 0; video_on = 0;
    sprite_x = 10'd100; sprite_y = 10'd50; facing_left = 0;
    frame_tick = 0; anim_req = 0; key_force = 0;
    repeat (3) step();
    check("rst_addr", {18'd0, rom_addr}, 0);
    check("rst_sel", {30'd0, rom_sel}, 0);
    check("rst_valid", {31'd0, pix_valid}, 0);
    check("rst_punch", {31'd0, punch_active}, 0);
    rst_n = 1'b1;
    step();

    // Address corners
    video_on = 1'b1;
    hcount = 10'd100; vcount = 10'd50; step();
    check("addr_origin", {18'd0, rom_addr}, 0);
    hcount = 10'd227; vcount = 10'd177; step();
    check("addr_corner", {18'd0, rom_addr}, 16383);
    probe(10'd228, 10'd50, "right_edge_invalid", 1'b0);
    probe(10'd99, 10'd50, "left_edge_invalid", 1'b0);
    probe(10'd100, 10'd49, "top_edge_invalid", 1'b0);

    // Row-0 sweep: pixel data equals dx, two clocks after sampling
    for (int i = 0; i < 140; i++) begin
      exp_v[i]   = (i < 128);
      exp_rgb[i] = (i < 128) ? 12'(i) : 12'h000;
    end
    for (int i = 0; i < 140; i++) begin
      hcount = 10'(100 + i); vcount = 10'd50;
      step();
      check($sformatf("sweep_addr[%0d]", i), {18'd0, rom_addr}, (i < 128) ? i : 0);
      if (i >= 2) begin
        check($sformatf("sweep_rgb[%0d]", i - 2), {20'd0, pix_rgb}, {20'd0, exp_rgb[i-2]});
        check($sformatf("sweep_valid[%0d]", i - 2), {31'd0, pix_valid}, {31'd0, exp_v[i-2]});
        check($sformatf("sweep_opaque[%0d]", i - 2), {31'd0, pix_opaque}, {31'd0, exp_v[i-2]});
      end
    end

    // Key color: valid but transparent
    key_force = 1'b1;
    probe(10'd150, 10'd60, "key_valid", 1'b1);
    check("key_opaque", {31'd0, pix_opaque}, 0);
    check("key_rgb", {20'd0, pix_rgb}, 32'hF0F);
    key_force = 1'b0;
    video_on = 1'b0;
    probe(10'd150, 10'd60, "video_off_invalid", 1'b0);
    video_on = 1'b1;

    // No wrap at the right edge
    sprite_x = 10'd1000;
    probe(10'd1000, 10'd60, "nowrap_1000", 1'b1);
    probe(10'd1023, 10'd60, "nowrap_1023", 1'b1);
    probe(10'd0, 10'd60, "nowrap_0", 1'b0);
    probe(10'd127, 10'd60, "nowrap_127", 1'b0);
    sprite_x = 10'd100;

    // Walk cycle; facing_left toggled mid-frame
    anim_req = 2'd1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      check($sformatf("walk_sel[%0d]", t), {30'd0, rom_sel}, (t <= 8) ? 1 : (t <= 16) ? 2 : 1);
      if (t == 3) begin
        facing_left = 1'b1;
        repeat (4) step();
        check("rev_hold", {31'd0, rom_reverse}, 0);
      end
      if (t == 4) check("rev_update", {31'd0, rom_reverse}, 1);
    end
    anim_req = 2'd0;
    tick();
    check("walk_to_idle", {30'd0, rom_sel}, 0);

    // One-shot punch; a second request mid-punch is ignored
    anim_req = 2'd2;
    tick();
    anim_req = 2'd0;
    check("punch_sel", {30'd0, rom_sel}, 3);
    for (int t = 2; t <= 13; t++) begin
      if (t == 5) anim_req = 2'd2;
      tick();
      anim_req = 2'd0;
      check($sformatf("punch_active[%0d]", t), {31'd0, punch_active}, (t <= 12) ? 1 : 0);
    end
    check("punch_end_sel", {30'd0, rom_sel}, 0);

    // Async reset mid-punch with pixels in flight
    anim_req = 2'd2;
    tick();
    anim_req = 2'd0;
    hcount = 10'd120; vcount = 10'd70;
    repeat (3) step();
    check("pre_rst_valid", {31'd0, pix_valid}, 1);
    check("pre_rst_punch", {31'd0, punch_active}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, pix_valid}, 0);
    check("arst_rgb", {20'd0, pix_rgb}, 0);
    check("arst_addr", {18'd0, rom_addr}, 0);
    check("arst_punch", {31'd0, punch_active}, 0);
    check("arst_sel", {30'd0, rom_sel}, 0);
    check("arst_rev", {31'd0, rom_reverse}, 0);
    step();
    rst_n = 1'b1;
    step();
    tick();
    check("post_rst_sel", {30'd0, rom_sel}, 0);
    check("post_rst_punch", {31'd0, punch_active}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
